tcm_mp_ctrl: RTL and testbench

Parametrised multi-port tightly-coupled-memory controller, the next generation of the single-requester ITCM/DTCM controllers. Arbitrates `NCH` valid/ready command channels (e.g. LSU, IFU, debug/DMA) onto one single-port synchronous SRAM with 1-cycle read latency. Returns one response per accepted command on the issuing channel's response port. Sits between the core's memory-side ports and the TCM SRAM macro at the cpu top level.

---
 rtl/tcm_mp_ctrl_pkg.sv | 20 ++
 rtl/tcm_rr_arb.sv | 76 +++++++
 rtl/tcm_mp_ctrl.sv | 136 +++++++++++++
 tb/tb_tcm_mp_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_mp_ctrl_pkg.sv
// Shared TCM defaults: requester count, address/data widths, the command
// opcode encoding and a helper for channel-index widths.
package tcm_mp_ctrl_pkg;

    localparam int TCM_NCH = 2;
    localparam int TCM_AW  = 16;
    localparam int TCM_DW  = 32;

    // Command opcode as carried on cmd_read
    typedef enum logic {
        CMD_WRITE = 1'b0,
        CMD_READ  = 1'b1
    } cmd_op_e;

    // Width of a channel index; a single channel still needs one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcm_rr_arb.sv
// Request vector to one-hot grant for the TCM controller.
// Build option TCM_RR_ARB_EN: defined selects round-robin arbitration with a
// 'last' pointer; undefined selects fixed priority (lowest index wins).
module tcm_rr_arb
    import tcm_mp_ctrl_pkg::*;
#(
    parameter  int NCH = TCM_NCH,
    localparam int IDW = id_width(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [IDW-1:0] grant_id
);

`ifdef TCM_RR_ARB_EN
    logic [IDW-1:0] last;

    // Pick the first requester found after the previous winner, wrapping
    always_comb begin
        int       pos;
        logic     found;
        logic [IDW-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        pos      = 0;
        idx      = '0;
        for (int k = 0; k < NCH; k++) begin
            pos = int'(last) + 1 + k;
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            idx = IDW'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

    // Remember the winner only when its command is actually accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= IDW'(NCH - 1);
        end else if (advance) begin
            last <= grant_id;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = clk ^ rst_n ^ advance;

    // Lowest-index requester wins
    always_comb begin
        logic     found;
        logic [IDW-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = IDW'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/tcm_mp_ctrl.sv
// Multi-port TCM controller: arbitrates NCH command channels onto one
// single-port SRAM with 1-cycle read latency and returns one response per
// accepted command. Build option TCM_RR_ARB_EN selects round-robin
// arbitration (see tcm_rr_arb); without it, fixed priority is used.
module tcm_mp_ctrl
    import tcm_mp_ctrl_pkg::*;
#(
    parameter int NCH    = TCM_NCH,
    parameter int AW     = TCM_AW,
    parameter int DW     = TCM_DW,
    parameter int MW     = DW / 8,
    parameter int RAM_AW = AW - $clog2(MW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    cmd_valid,
    output logic [NCH-1:0]    cmd_ready,
    input  logic [NCH-1:0]    cmd_read,
    input  logic [NCH*AW-1:0] cmd_addr,
    input  logic [NCH*DW-1:0] cmd_wdata,
    input  logic [NCH*MW-1:0] cmd_wmask,
    output logic [NCH-1:0]    rsp_valid,
    input  logic [NCH-1:0]    rsp_ready,
    output logic [NCH*DW-1:0] rsp_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [MW-1:0]     ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int IDW = id_width(NCH);
    localparam int LSB = $clog2(MW);

    logic           rsp_pend;
    logic [IDW-1:0] pend_id;
    cmd_op_e        pend_op;
    logic           hold_vld;
    logic [DW-1:0]  hold_data;

    logic           rsp_hs;
    logic           access_ok;
    logic [NCH-1:0] req;
    logic [NCH-1:0] grant;
    logic [IDW-1:0] grant_id;
    logic           cmd_hs;
    logic           sel_read;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [MW-1:0]  sel_mask;
    logic [DW-1:0]  rsp_data;
    logic           unused_addr;

    // A new access may start once the response slot is free or freeing now
    assign rsp_hs    = rsp_pend & rsp_ready[pend_id];
    assign access_ok = rst_n & (~rsp_pend | rsp_hs);
    assign req       = cmd_valid & {NCH{access_ok}};
    assign cmd_hs    = |grant;
    assign cmd_ready = grant;

    tcm_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .advance  (cmd_hs),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // One-hot mux of the granted channel's command fields
    always_comb begin
        sel_read  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_mask  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                sel_read  = sel_read  | cmd_read[k];
                sel_addr  = sel_addr  | cmd_addr[k*AW +: AW];
                sel_wdata = sel_wdata | cmd_wdata[k*DW +: DW];
                sel_mask  = sel_mask  | cmd_wmask[k*MW +: MW];
            end
        end
    end

    // Byte-offset bits are dropped when forming the word address
    assign unused_addr = ^sel_addr;
    assign ram_cs      = cmd_hs;
    assign ram_we      = cmd_hs & ~sel_read;
    assign ram_addr    = RAM_AW'(sel_addr >> LSB);
    assign ram_wem     = sel_read ? '0 : sel_mask;
    assign ram_din     = sel_wdata;

    // Route the pending response to its channel; held data wins over live SRAM
    always_comb begin
        rsp_valid = '0;
        if (rst_n && rsp_pend) begin
            rsp_valid[pend_id] = 1'b1;
        end
        if (hold_vld) begin
            rsp_data = hold_data;
        end else if (pend_op == CMD_READ) begin
            rsp_data = ram_dout;
        end else begin
            rsp_data = '0;
        end
    end

    assign rsp_rdata = {NCH{rsp_data}};

    // Response stage: load on accept, retire on handshake, capture on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pend  <= 1'b0;
            hold_vld  <= 1'b0;
            pend_id   <= '0;
            pend_op   <= CMD_WRITE;
            hold_data <= '0;
        end else if (cmd_hs) begin
            rsp_pend <= 1'b1;
            pend_id  <= grant_id;
            pend_op  <= sel_read ? CMD_READ : CMD_WRITE;
            hold_vld <= 1'b0;
        end else if (rsp_hs) begin
            rsp_pend <= 1'b0;
            hold_vld <= 1'b0;
        end else if (rsp_pend && (pend_op == CMD_READ) && !hold_vld) begin
            hold_vld  <= 1'b1;
            hold_data <= ram_dout;
        end
    end

endmodule

// File: tb/tb_tcm_mp_ctrl.sv
// Directed self-checking bench for tcm_mp_ctrl with a behavioural SRAM.
// Expected grant order follows the TCM_RR_ARB_EN build option.
module tb_tcm_mp_ctrl;

    localparam int NCH    = 2;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int MW     = 4;
    localparam int RAM_AW = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    cmd_valid;
    logic [NCH-1:0]    cmd_ready;
    logic [NCH-1:0]    cmd_read;
    logic [NCH*AW-1:0] cmd_addr;
    logic [NCH*DW-1:0] cmd_wdata;
    logic [NCH*MW-1:0] cmd_wmask;
    logic [NCH-1:0]    rsp_valid;
    logic [NCH-1:0]    rsp_ready;
    logic [NCH*DW-1:0] rsp_rdata;
    logic              ram_cs;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [MW-1:0]     ram_wem;
    logic [DW-1:0]     ram_din;
    logic [DW-1:0]     ram_dout;

    logic [DW-1:0] mem [0:(1<<RAM_AW)-1];
    logic [DW-1:0] mem_dout;
    logic          dout_force_en;
    logic [DW-1:0] dout_force;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcm_mp_ctrl #(
        .NCH(NCH), .AW(AW), .DW(DW), .MW(MW), .RAM_AW(RAM_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wem   (ram_wem),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // SRAM output can be overridden to prove the controller holds its data
    assign ram_dout = dout_force_en ? dout_force : mem_dout;

    // Behavioural single-port SRAM, 1-cycle read latency, byte write mask
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (ram_cs) begin
            if (ram_we) begin
                w = mem[ram_addr];
                for (int b = 0; b < MW; b++) begin
                    if (ram_wem[b]) w[b*8 +: 8] = ram_din[b*8 +: 8];
                end
                mem[ram_addr] <= w;
            end else begin
                mem_dout <= mem[ram_addr];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic valid, input logic read,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [MW-1:0] mask);
        cmd_valid[ch]            = valid;
        cmd_read[ch]             = read;
        cmd_addr[ch*AW +: AW]    = addr;
        cmd_wdata[ch*DW +: DW]   = wdata;
        cmd_wmask[ch*MW +: MW]   = mask;
    endtask

    logic [NCH-1:0] exp_grant [0:3];

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = '0;
        mem[16'h10]   = 32'hDEADBEEF;
        mem[2]        = 32'hAABBCCDD;
        mem_dout      = '0;
        dout_force_en = 1'b0;
        dout_force    = '0;
        cmd_valid     = '0;
        cmd_read      = '0;
        cmd_addr      = '0;
        cmd_wdata     = '0;
        cmd_wmask     = '0;
        rsp_ready     = '1;

`ifdef TCM_RR_ARB_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
`endif

        // Reset with requests present: everything gated off
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
        #1;
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        checkOutput("rst_ram_cs",    64'(ram_cs),    64'h0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        step();
        step();
        rst_n     = 1'b1;
        cmd_valid = '0;
        step();

        // Single read on channel 0
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        #1;
        checkOutput("rd_cmd_ready", 64'(cmd_ready), 64'h1);
        checkOutput("rd_ram_cs",    64'(ram_cs),    64'h1);
        checkOutput("rd_ram_we",    64'(ram_we),    64'h0);
        checkOutput("rd_ram_addr",  64'(ram_addr),  64'h10);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("rd_rdata0",    64'(rsp_rdata[31:0]),  64'hDEADBEEF);
        checkOutput("rd_rdata1",    64'(rsp_rdata[63:32]), 64'hDEADBEEF);
        step();
        checkOutput("rd_rsp_done",  64'(rsp_valid), 64'h0);

        // Byte write on channel 1, then readback from channel 1
        applyStimulus(1, 1'b1, 1'b0, 16'h0008, 32'h11223344, 4'b0100);
        #1;
        checkOutput("wr_cmd_ready", 64'(cmd_ready), 64'h2);
        checkOutput("wr_ram_we",    64'(ram_we),    64'h1);
        checkOutput("wr_ram_wem",   64'(ram_wem),   64'h4);
        checkOutput("wr_ram_addr",  64'(ram_addr),  64'h2);
        checkOutput("wr_ram_din",   64'(ram_din),   64'h11223344);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("wr_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("wr_rdata",     64'(rsp_rdata[63:32]), 64'h0);
        step();
        applyStimulus(1, 1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("wrb_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("wrb_rdata",     64'(rsp_rdata[63:32]), 64'hAA22CCDD);
        step();

        // Contention: both channels valid for four cycles
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput($sformatf("arb_grant%0d", c), 64'(cmd_ready), 64'(exp_grant[c]));
            if (c > 0) begin
                checkOutput($sformatf("arb_rsp%0d", c), 64'(rsp_valid), 64'(exp_grant[c-1]));
                checkOutput($sformatf("arb_data%0d", c), 64'(rsp_rdata[31:0]),
                            (exp_grant[c-1] == 2'b01) ? 64'hDEADBEEF : 64'hAA22CCDD);
            end
            step();
        end
        cmd_valid = '0;
        #1;
        checkOutput("arb_rsp_last",  64'(rsp_valid), 64'(exp_grant[3]));
        checkOutput("arb_data_last", 64'(rsp_rdata[31:0]),
                    (exp_grant[3] == 2'b01) ? 64'hDEADBEEF : 64'hAA22CCDD);
        step();

        // Backpressure: response held three cycles while SRAM output changes
        rsp_ready = '0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        #1;
        checkOutput("bp_cmd_ready", 64'(cmd_ready), 64'h1);
        step();
        cmd_valid[0] = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                dout_force_en = 1'b1;
                dout_force    = 32'h12345678;
            end else if (c == 3) begin
                dout_force = 32'h0BADF00D;
            end
            #1;
            checkOutput($sformatf("bp_rsp%0d", c),   64'(rsp_valid), 64'h1);
            checkOutput($sformatf("bp_data%0d", c),  64'(rsp_rdata[31:0]), 64'hDEADBEEF);
            checkOutput($sformatf("bp_ready%0d", c), 64'(cmd_ready), 64'h0);
            step();
        end
        rsp_ready = '1;
        #1;
        checkOutput("bp_rsp4",   64'(rsp_valid), 64'h1);
        checkOutput("bp_data4",  64'(rsp_rdata[31:0]), 64'hDEADBEEF);
        checkOutput("bp_ready4", 64'(cmd_ready), 64'h2);
        dout_force_en = 1'b0;
        step();
        cmd_valid = '0;
        #1;
        checkOutput("bp_next_rsp",  64'(rsp_valid), 64'h2);
        checkOutput("bp_next_data", 64'(rsp_rdata[63:32]), 64'hAA22CCDD);
        step();

        // Reset while a response is pending
        rsp_ready = '0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("rm_pending", 64'(rsp_valid), 64'h1);
        rst_n = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b1, 16'h0008, 32'h0, 4'h0);
        #1;
        checkOutput("rm_rsp_forced", 64'(rsp_valid), 64'h0);
        checkOutput("rm_cmd_forced", 64'(cmd_ready), 64'h0);
        step();
        rst_n     = 1'b1;
        rsp_ready = '1;
        #1;
        checkOutput("rm_dropped", 64'(rsp_valid), 64'h0);
        checkOutput("rm_grant0",  64'(cmd_ready), 64'h1);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("rm_rsp",  64'(rsp_valid), 64'h1);
        checkOutput("rm_data", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
        step();

        // Write with all-zero mask still accesses and responds
        applyStimulus(0, 1'b1, 1'b0, 16'h0040, 32'hFFFFFFFF, 4'h0);
        #1;
        checkOutput("zm_ram_cs",  64'(ram_cs),  64'h1);
        checkOutput("zm_ram_we",  64'(ram_we),  64'h1);
        checkOutput("zm_ram_wem", 64'(ram_wem), 64'h0);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("zm_rsp",  64'(rsp_valid), 64'h1);
        checkOutput("zm_data", 64'(rsp_rdata[31:0]), 64'h0);
        step();

        // Low address bits ignored
        applyStimulus(0, 1'b1, 1'b1, 16'h0043, 32'h0, 4'h0);
        #1;
        checkOutput("lb_ram_addr", 64'(ram_addr), 64'h10);
        step();
        cmd_valid = '0;
        #1;
        checkOutput("lb_rsp",  64'(rsp_valid), 64'h1);
        checkOutput("lb_data", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
